vga_sync_decoder: RTL and testbench

VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

---
 rtl/vga_sync_decoder.sv | 150 +++++++++++++++
 tb/tb_vga_sync_decoder.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_decoder.sv
// VGA sync decoder: recovers pixel column/line from h_sync and v_sync,
// with a four-state acquisition FSM and a missing-h_sync watchdog.
module vga_sync_decoder #(
   parameter int HA_END = 639,
   parameter int HS_STA = HA_END + 16,
   parameter int LINE   = 799,
   parameter int VA_END = 479,
   parameter int VS_STA = VA_END + 10,
   parameter int SCREEN = 524,
   parameter int WDOG   = 1600
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       h_sync,
   input  logic       v_sync,
   output logic [9:0] x,
   output logic [9:0] y,
   output logic       display,
   output logic       locked,
   output logic       frame_start,
   output logic       sync_err
);

   localparam int WW = $clog2(WDOG + 1);

   localparam logic [1:0] S_SEARCH = 2'd0;
   localparam logic [1:0] S_HACQ   = 2'd1;
   localparam logic [1:0] S_HLOCK  = 2'd2;
   localparam logic [1:0] S_LOCKED = 2'd3;

   localparam logic [9:0] HS_POS   = 10'(HS_STA);
   localparam logic [9:0] HS_LOAD  = 10'(HS_STA + 1);
   localparam logic [9:0] LINE_END = 10'(LINE);
   localparam logic [9:0] SCR_END  = 10'(SCREEN);
   localparam logic [9:0] VS_POS   = 10'(VS_STA);
   localparam logic [9:0] HA_LAST  = 10'(HA_END);
   localparam logic [9:0] VA_LAST  = 10'(VA_END);

   localparam logic [WW-1:0] WD_LAST = WW'(WDOG - 1);
   localparam logic [WW-1:0] WD_MAX  = WW'(WDOG);

   logic [1:0]    state_q, state_d;
   logic [9:0]    hx_q, hx_d;
   logic [9:0]    vy_q, vy_d;
   logic [9:0]    vy_inc;
   logic [WW-1:0] wdog_q, wdog_d;
   logic          hs_q, vs_q;
   logic          err_q, err_d;

   logic h_fall, v_fall, h_ok, at_sol, wrap, wd_trip;

   always_comb begin
      h_fall  = ~h_sync & hs_q;
      v_fall  = ~v_sync & vs_q;
      h_ok    = (hx_q == HS_POS);
      at_sol  = (hx_q == '0);
      wrap    = (hx_q == LINE_END);
      wd_trip = (state_q != S_SEARCH) && !h_fall
             && (wdog_q == WD_LAST);
   end

   always_comb begin
      state_d = state_q;
      err_d   = 1'b0;
      vy_d    = '0;

      if (h_fall)    hx_d = HS_LOAD;
      else if (wrap) hx_d = '0;
      else           hx_d = hx_q + 10'd1;

      if (wrap && !h_fall)
         vy_inc = (vy_q == SCR_END) ? '0 : vy_q + 10'd1;
      else
         vy_inc = vy_q;

      if (h_fall)                wdog_d = '0;
      else if (wdog_q == WD_MAX) wdog_d = wdog_q;
      else                       wdog_d = wdog_q + WW'(1);

      unique case (state_q)
         S_SEARCH: begin
            if (h_fall) state_d = S_HACQ;
         end
         S_HACQ: begin
            if (h_fall) begin
               if (h_ok) state_d = S_HLOCK;
               else      err_d   = 1'b1;
            end
         end
         S_HLOCK: begin
            if (h_fall && !h_ok) begin
               state_d = S_HACQ;
               err_d   = 1'b1;
            end else if (v_fall && at_sol) begin
               state_d = S_LOCKED;
               vy_d    = VS_POS;
            end
            if (v_fall && !at_sol) err_d = 1'b1;
         end
         S_LOCKED: begin
            // at hx==0 of the sync line vy has already stepped to VS_STA
            if ((h_fall && !h_ok) ||
                (v_fall && !(at_sol && vy_q == VS_POS))) begin
               state_d = S_HACQ;
               err_d   = 1'b1;
            end else if (v_fall) begin
               vy_d = VS_POS;
            end else begin
               vy_d = vy_inc;
            end
         end
         default: state_d = S_SEARCH;
      endcase

      if (wd_trip) begin
         state_d = S_SEARCH;
         hx_d    = '0;
         vy_d    = '0;
         err_d   = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_SEARCH;
         hx_q    <= '0;
         vy_q    <= '0;
         wdog_q  <= '0;
         hs_q    <= 1'b1;
         vs_q    <= 1'b1;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         hx_q    <= hx_d;
         vy_q    <= vy_d;
         wdog_q  <= wdog_d;
         hs_q    <= h_sync;
         vs_q    <= v_sync;
         err_q   <= err_d;
      end
   end

   assign x           = hx_q;
   assign y           = vy_q;
   assign locked      = (state_q == S_LOCKED);
   assign display     = locked && (hx_q <= HA_LAST) && (vy_q <= VA_LAST);
   assign frame_start = locked && wrap && (vy_q == SCR_END);
   assign sync_err    = err_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder on a scaled 20x10 timing: hand vectors
// for the acquisition FSM, then a timing generator with a scoreboard.
module tb_vga_sync_decoder;

   localparam int T_HA_END = 19;
   localparam int T_HS_STA = 23;
   localparam int T_HS_END = 26;
   localparam int T_LINE   = 31;
   localparam int T_VA_END = 9;
   localparam int T_VS_STA = 11;
   localparam int T_VS_END = 12;
   localparam int T_SCREEN = 14;
   localparam int T_WDOG   = 64;
   localparam int T_FRAME  = (T_LINE + 1) * (T_SCREEN + 1);
   localparam int T_ACT    = (T_HA_END + 1) * (T_VA_END + 1);

   localparam int M_FREE = 0;
   localparam int M_LOCK = 1;
   localparam int M_UNL  = 2;
   localparam int M_UNLX = 3;
   localparam int M_RST  = 4;
   localparam int M_HERR = 5;

   typedef struct {
      logic       cx, cy, cst, cerr, cnt;
      logic [9:0] x, y;
      logic       lk, disp, fs, err;
      string      tag;
   } exp_t;

   typedef struct {
      logic       r, h, v;
      int         rep;
      logic [9:0] ex, ey;
      logic       elk, eerr;
      string      tag;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       h_sync = 1'b1;
   logic       v_sync = 1'b1;
   logic [9:0] x, y;
   logic       display, locked, frame_start, sync_err;

   exp_t exp_q[$];
   vec_t vq[$];
   exp_t ce;
   int   fs_at[$];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   fs_n = 0;
   int   disp_n = 0;
   int   err_n = 0;
   int   gx = 0;
   int   gy = 0;

   always #5 clk = ~clk;

   vga_sync_decoder #(
      .HA_END(T_HA_END),
      .HS_STA(T_HS_STA),
      .LINE  (T_LINE),
      .VA_END(T_VA_END),
      .VS_STA(T_VS_STA),
      .SCREEN(T_SCREEN),
      .WDOG  (T_WDOG)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .h_sync     (h_sync),
      .v_sync     (v_sync),
      .x          (x),
      .y          (y),
      .display    (display),
      .locked     (locked),
      .frame_start(frame_start),
      .sync_err   (sync_err)
   );

   task automatic chk(input string nm, input string tag,
                      input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s/%s: got %0d want %0d at cycle %0d",
                  tag, nm, act, req, cyc);
      end
   endtask

   function automatic exp_t blank_e(input string tag);
      exp_t e;
      e.cx = 0; e.cy = 0; e.cst = 0; e.cerr = 0; e.cnt = 0;
      e.x = '0; e.y = '0;
      e.lk = 0; e.disp = 0; e.fs = 0; e.err = 0;
      e.tag = tag;
      return e;
   endfunction

   function automatic void addv(input logic r, h, v, input int rep,
                                input int ex, ey, input logic lk, er,
                                input string tag);
      vec_t t;
      t.r = r; t.h = h; t.v = v; t.rep = rep;
      t.ex = 10'(ex); t.ey = 10'(ey);
      t.elk = lk; t.eerr = er; t.tag = tag;
      vq.push_back(t);
   endfunction

   always @(posedge clk) begin
      #1;
      cyc++;
      if (exp_q.size() != 0) begin
         ce = exp_q.pop_front();
         if (ce.cx) chk("x", ce.tag, int'(x), int'(ce.x));
         if (ce.cy) chk("y", ce.tag, int'(y), int'(ce.y));
         if (ce.cst) begin
            chk("locked", ce.tag, int'(locked), int'(ce.lk));
            chk("display", ce.tag, int'(display), int'(ce.disp));
            chk("frame_start", ce.tag, int'(frame_start), int'(ce.fs));
         end
         if (ce.cerr) chk("sync_err", ce.tag, int'(sync_err), int'(ce.err));
         if (ce.cnt) begin
            if (frame_start) begin
               fs_n++;
               fs_at.push_back(cyc);
            end
            if (display) disp_n++;
            if (sync_err) err_n++;
         end
      end
   end

   task automatic drive(input logic r, h, v, input exp_t e);
      @(negedge clk);
      rst    = r;
      h_sync = h;
      v_sync = v;
      exp_q.push_back(e);
   endtask

   task automatic gstep(input logic r, input int mode, input int hsh,
                        input logic cnt, input string tag);
      logic h, v;
      int   nx, ny;
      exp_t e;
      h  = !((gx >= T_HS_STA + hsh) && (gx <= T_HS_END + hsh));
      v  = !((gy >= T_VS_STA) && (gy <= T_VS_END));
      nx = (gx == T_LINE) ? 0 : gx + 1;
      ny = (gx == T_LINE) ? ((gy == T_SCREEN) ? 0 : gy + 1) : gy;
      e  = blank_e(tag);
      e.cnt = cnt;
      case (mode)
         M_LOCK: begin
            e.cx = 1; e.x = 10'(nx);
            e.cy = 1; e.y = 10'(ny);
            e.cst = 1; e.lk = 1;
            e.disp = (nx <= T_HA_END) && (ny <= T_VA_END);
            e.fs = (nx == T_LINE) && (ny == T_SCREEN);
            e.cerr = 1; e.err = 0;
         end
         M_UNL, M_UNLX: begin
            e.cy = 1; e.y = '0;
            e.cst = 1;
            if (mode == M_UNLX) begin
               e.cx = 1; e.x = 10'(nx);
            end
         end
         M_RST: begin
            e.cx = 1; e.cy = 1; e.cst = 1; e.cerr = 1;
         end
         M_HERR: begin
            e.cx = 1; e.x = 10'(T_HS_STA + 1);
            e.cy = 1; e.cst = 1;
            e.cerr = 1; e.err = 1;
         end
         default: ;
      endcase
      drive(r, h, v, e);
      gx = nx;
      gy = ny;
   endtask

   task automatic relock(input string tag, input int errs);
      bit al = 0;
      err_n = 0;
      while (!(gx == 0 && gy == T_VS_STA)) begin
         if (gx == T_HS_STA) al = 1;
         gstep(1'b0, al ? M_UNLX : M_UNL, 0, 1'b1, tag);
      end
      gstep(1'b0, M_LOCK, 0, 1'b0, {tag, "_lock"});
      @(posedge clk);
      #2;
      chk("err_pulses", tag, err_n, errs);
   endtask

   initial begin
      #1000000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

   initial begin
      exp_t e;
      addv(1, 1, 1,  2,  0,  0, 0, 0, "reset");
      addv(0, 1, 1,  5,  5,  0, 0, 0, "search_cnt");
      addv(0, 0, 1,  1, 24,  0, 0, 0, "first_hfall");
      addv(0, 0, 1,  2, 26,  0, 0, 0, "hsync_low");
      addv(0, 1, 1,  1, 27,  0, 0, 0, "hsync_rise");
      addv(0, 0, 1,  1, 24,  0, 0, 1, "acq_bad_hfall");
      addv(0, 1, 1,  1, 25,  0, 0, 0, "err_one_cycle");
      addv(0, 1, 1, 30, 23,  0, 0, 0, "acq_wrap");
      addv(0, 0, 1,  1, 24,  0, 0, 0, "acq_good_hfall");
      addv(0, 1, 1,  7, 31,  0, 0, 0, "hlock_run");
      addv(0, 1, 1,  1,  0,  0, 0, 0, "hlock_wrap_y0");
      addv(0, 1, 1,  5,  5,  0, 0, 0, "hlock_pos5");
      addv(0, 1, 0,  1,  6,  0, 0, 1, "vfall_hx5");
      addv(0, 1, 1,  1,  7,  0, 0, 0, "stay_hlock");
      addv(0, 1, 1, 25,  0,  0, 0, 0, "to_sol");
      addv(0, 1, 0,  1,  1, 11, 1, 0, "lock_vfall");
      addv(0, 1, 0, 22, 23, 11, 1, 0, "wdog_edge");
      addv(0, 1, 0,  1,  0,  0, 0, 1, "wdog_trip");
      addv(0, 1, 1,  1,  1,  0, 0, 0, "search_again");

      for (int i = 0; i < vq.size(); i++) begin
         for (int k = 0; k < vq[i].rep; k++) begin
            e = blank_e(vq[i].tag);
            if (k == vq[i].rep - 1) begin
               e.cx = 1; e.x = vq[i].ex;
               e.cy = 1; e.y = vq[i].ey;
               e.cst = 1; e.lk = vq[i].elk;
               e.cerr = 1; e.err = vq[i].eerr;
            end
            drive(vq[i].r, vq[i].h, vq[i].v, e);
         end
      end

      gx = 0;
      gy = 2;
      repeat (10) gstep(1'b1, M_RST, 0, 1'b0, "gen_reset");
      relock("acqA", 0);

      fs_n = 0;
      disp_n = 0;
      err_n = 0;
      fs_at.delete();
      repeat (3 * T_FRAME) gstep(1'b0, M_LOCK, 0, 1'b1, "frames");
      @(posedge clk);
      #2;
      chk("fs_count", "frames", fs_n, 3);
      chk("disp_cycles", "frames", disp_n, 3 * T_ACT);
      chk("err_pulses", "frames", err_n, 0);
      for (int i = 1; i < fs_at.size(); i++)
         chk("fs_gap", "frames", fs_at[i] - fs_at[i-1], T_FRAME);

      while (!(gx == 0 && gy == 2))
         gstep(1'b0, M_LOCK, 0, 1'b0, "preB");
      while (gx != T_HS_STA + 3)
         gstep(1'b0, M_LOCK, 3, 1'b0, "shiftB");
      gstep(1'b0, M_HERR, 3, 1'b0, "shift_err");
      while (gx != 0)
         gstep(1'b0, M_UNL, 3, 1'b0, "shiftB_tail");
      relock("relockB", 1);
      repeat (2 * (T_LINE + 1)) gstep(1'b0, M_LOCK, 0, 1'b0, "postB");

      while (!(gx == 15 && gy == 5))
         gstep(1'b0, M_LOCK, 0, 1'b0, "preC");
      gstep(1'b1, M_RST, 0, 1'b0, "rst_midframe");
      relock("relockC", 0);
      repeat (T_FRAME) gstep(1'b0, M_LOCK, 0, 1'b0, "postC");

      @(posedge clk);
      #2;
      chk("sb_empty", "end", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
